// File: rtl/scan_sequencer_if.sv
// Register bus, DAC, counter and result signals of the scan sequencer.
// The slave modport is the sequencer; the master modport is the host/board side.
interface scan_sequencer_if #(
    parameter int DAC_BITS = 12
);
    logic [7:0]          addr;
    logic [7:0]          data;
    logic                write;
    logic [7:0]          data_out;
    logic [DAC_BITS-1:0] dac_code;
    logic                dac_load;
    logic                dac_busy;
    logic                cnt_clear;
    logic                cnt_enable;
    logic [31:0]         count_value;
    logic                res_valid;
    logic [7:0]          res_step;
    logic [31:0]         res_count;
    logic                res_ack;
    logic                busy;
    logic                done;

    modport slave (
        input  addr, data, write, dac_busy, count_value, res_ack,
        output data_out, dac_code, dac_load, cnt_clear, cnt_enable,
               res_valid, res_step, res_count, busy, done
    );

    modport master (
        output addr, data, write, dac_busy, count_value, res_ack,
        input  data_out, dac_code, dac_load, cnt_clear, cnt_enable,
               res_valid, res_step, res_count, busy, done
    );
endinterface

// File: rtl/scan_sequencer.sv
// DAC-threshold scan controller: per point loads the DAC, waits for SPI and settle,
// gates the pulse counter for a fixed window and hands the count to the consumer.
module scan_sequencer #(
    parameter logic [7:0] BASE_ADDR = 8'h40,
    parameter int         DAC_BITS  = 12
) (
    input  logic            clock50Mhz,
    input  logic            reset,
    scan_sequencer_if.slave bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_DACWAIT, S_SETTLE, S_CLEAR, S_COUNT, S_HOLD, S_REPORT, S_DONE
    } state_t;

    logic [7:0] offset;
    logic       in_range;
    logic [7:0] cfg_val [8];

    assign offset   = bus.addr - BASE_ADDR;
    assign in_range = (bus.addr >= BASE_ADDR) && (offset <= 8'd10);

    // Offsets 0..7 are plain config bytes; the two code-high bytes keep only 4 bits.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_cfg
            localparam logic [7:0] MASK = (gi == 1 || gi == 3) ? 8'h0F : 8'hFF;
            logic [7:0] reg_q;
            always_ff @(posedge clock50Mhz) begin
                if (reset)
                    reg_q <= '0;
                else if (bus.write && in_range && offset == 8'(gi))
                    reg_q <= bus.data & MASK;
            end
            assign cfg_val[gi] = reg_q;
        end
    endgenerate

    logic ctrl_wr, start_cmd, abort_cmd;
    assign ctrl_wr   = bus.write && in_range && (offset == 8'd8);
    assign abort_cmd = ctrl_wr && bus.data[1];
    assign start_cmd = ctrl_wr && bus.data[0] && !bus.data[1];

    state_t              state_q, state_d;
    logic [23:0]         timer_q, timer_d;
    logic [7:0]          idx_q, idx_d, npts_q, npts_d, settle_q, settle_d;
    logic [DAC_BITS-1:0] code_q, code_d, step_q, step_d;
    logic [15:0]         window_q, window_d;
    logic [7:0]          res_step_q, res_step_d;
    logic [31:0]         res_count_q, res_count_d;
    logic                done_q, done_d, aborted_q, aborted_d, sat_q, sat_d;

    logic [15:0]         window_word;
    logic [DAC_BITS:0]   code_sum;
    logic [23:0]         settle_end, window_end;
    logic                busy;

    assign window_word = {cfg_val[7], cfg_val[6]};
    assign code_sum    = {1'b0, code_q} + {1'b0, step_q};
    assign settle_end  = {8'b0, settle_q, 8'h00} - 24'd1;
    assign window_end  = {2'b0, window_q, 6'b0} - 24'd1;
    assign busy        = !(state_q == S_IDLE || state_q == S_DONE);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        code_d      = code_q;
        step_d      = step_q;
        npts_d      = npts_q;
        settle_d    = settle_q;
        window_d    = window_q;
        res_step_d  = res_step_q;
        res_count_d = res_count_q;
        done_d      = done_q;
        aborted_d   = aborted_q;
        sat_d       = sat_q;
        if (abort_cmd) begin
            state_d   = S_IDLE;
            aborted_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (state_q == S_DONE)
                        state_d = S_IDLE;
                    if (start_cmd) begin
                        idx_d     = '0;
                        code_d    = DAC_BITS'({cfg_val[1][3:0], cfg_val[0]});
                        step_d    = DAC_BITS'({cfg_val[3][3:0], cfg_val[2]});
                        npts_d    = cfg_val[4];
                        settle_d  = cfg_val[5];
                        window_d  = (window_word == 16'd0) ? 16'd1 : window_word;
                        aborted_d = 1'b0;
                        sat_d     = 1'b0;
                        done_d    = (cfg_val[4] == 8'd0);
                        state_d   = (cfg_val[4] == 8'd0) ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD:    state_d = S_DACWAIT;
                // timer_q != 0 guarantees at least two cycles here before trusting dac_busy
                S_DACWAIT: if (timer_q != 24'd0 && !bus.dac_busy)
                               state_d = (settle_q == 8'd0) ? S_CLEAR : S_SETTLE;
                S_SETTLE:  if (timer_q == settle_end) state_d = S_CLEAR;
                S_CLEAR:   state_d = S_COUNT;
                S_COUNT:   if (timer_q == window_end) state_d = S_HOLD;
                S_HOLD: begin
                    res_count_d = bus.count_value;
                    res_step_d  = idx_q;
                    state_d     = S_REPORT;
                end
                S_REPORT: begin
                    if (bus.res_ack) begin
                        if (idx_q == npts_q - 8'd1) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            idx_d   = idx_q + 8'd1;
                            state_d = S_LOAD;
                            if (code_sum[DAC_BITS]) begin
                                code_d = '1;
                                sat_d  = 1'b1;
                            end else begin
                                code_d = code_sum[DAC_BITS-1:0];
                            end
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        timer_d = (state_d != state_q) ? 24'd0 : timer_q + 24'd1;
    end

    always_ff @(posedge clock50Mhz) begin
        if (reset) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            idx_q       <= '0;
            code_q      <= '0;
            step_q      <= '0;
            npts_q      <= '0;
            settle_q    <= '0;
            window_q    <= '0;
            res_step_q  <= '0;
            res_count_q <= '0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            idx_q       <= idx_d;
            code_q      <= code_d;
            step_q      <= step_d;
            npts_q      <= npts_d;
            settle_q    <= settle_d;
            window_q    <= window_d;
            res_step_q  <= res_step_d;
            res_count_q <= res_count_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            sat_q       <= sat_d;
        end
    end

    always_comb begin
        bus.data_out = '0;
        if (in_range) begin
            if (offset < 8'd8)       bus.data_out = cfg_val[offset[2:0]];
            else if (offset == 8'd9) bus.data_out = {4'b0, sat_q, aborted_q, done_q, busy};
            else if (offset == 8'd10) bus.data_out = idx_q;
        end
    end

    assign bus.dac_code   = code_q;
    assign bus.dac_load   = (state_q == S_LOAD);
    assign bus.cnt_clear  = (state_q == S_CLEAR);
    assign bus.cnt_enable = (state_q == S_COUNT);
    assign bus.res_valid  = (state_q == S_REPORT);
    assign bus.res_step   = res_step_q;
    assign bus.res_count  = res_count_q;
    assign bus.busy       = busy;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_scan_sequencer.sv
// Randomized scoreboard bench for scan_sequencer: expected per-point codes, timings and
// results are queued when a scan is started and consumed by an independent monitor.
module tb_scan_sequencer;
    localparam logic [7:0] BASE = 8'h40;

    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    scan_sequencer_if bus ();
    scan_sequencer #(.BASE_ADDR(BASE), .DAC_BITS(12)) dut (
        .clock50Mhz(clk),
        .reset     (rst),
        .bus       (bus.slave)
    );

    typedef struct {
        logic [7:0]  step;
        logic [31:0] count;
    } res_t;

    logic [11:0] exp_code_q[$];
    int          exp_gap_q[$];
    int          exp_win_q[$];
    res_t        exp_res_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int dac_hold = 0;
    int ack_hold = -1;
    bit ignore_partial = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pulse counter peripheral: unrelated drift while idle so a missing clear is visible.
    logic [31:0] cnt_model;
    always @(posedge clk) begin
        if (rst)                 cnt_model <= 32'h1234;
        else if (bus.cnt_clear)  cnt_model <= 32'd0;
        else if (bus.cnt_enable) cnt_model <= cnt_model + 32'd1;
        else                     cnt_model <= cnt_model + 32'd7;
    end
    assign bus.count_value = cnt_model;

    // spidac: busy for dac_hold cycles after each load.
    initial begin
        int rem;
        rem = 0;
        bus.dac_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rem = 0;
                bus.dac_busy = 1'b0;
            end else if (bus.dac_load) begin
                rem = dac_hold;
                bus.dac_busy = 1'b0;
            end else if (rem > 0) begin
                bus.dac_busy = 1'b1;
                rem--;
            end else begin
                bus.dac_busy = 1'b0;
            end
        end
    end

    // Result consumer: random (or fixed) ack latency, random junk ack outside REPORT.
    initial begin
        int wait_n, target;
        bit in_rep;
        wait_n = 0; target = 0; in_rep = 1'b0;
        bus.res_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.res_valid) begin
                if (!in_rep) begin
                    in_rep = 1'b1;
                    wait_n = 0;
                    target = (ack_hold < 0) ? int'($urandom_range(0, 4)) : ack_hold;
                end
                bus.res_ack = (wait_n >= target);
                wait_n++;
            end else begin
                in_rep = 1'b0;
                bus.res_ack = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a load, clear, window or result.
    initial begin
        int load_cyc, en_run;
        bit rep_prev;
        logic [7:0]  held_step;
        logic [31:0] held_cnt;
        res_t r;
        load_cyc = 0; en_run = 0; rep_prev = 1'b0;
        held_step = '0; held_cnt = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                en_run = 0;
                rep_prev = 1'b0;
            end else begin
                if (bus.dac_load) begin
                    chk("load_outside_report", 64'(bus.res_valid), 64'd0);
                    chk("exp_code_avail", 64'(exp_code_q.size() > 0), 64'd1);
                    if (exp_code_q.size() > 0)
                        chk("dac_code", 64'(bus.dac_code), 64'(exp_code_q.pop_front()));
                    load_cyc = cyc;
                end
                if (bus.cnt_clear) begin
                    chk("exp_gap_avail", 64'(exp_gap_q.size() > 0), 64'd1);
                    if (exp_gap_q.size() > 0)
                        chk("load_to_clear", 64'(cyc - load_cyc), 64'(exp_gap_q.pop_front()));
                end
                if (bus.cnt_enable) begin
                    en_run++;
                end else if (en_run != 0) begin
                    if (!ignore_partial) begin
                        chk("exp_win_avail", 64'(exp_win_q.size() > 0), 64'd1);
                        if (exp_win_q.size() > 0)
                            chk("window_len", 64'(en_run), 64'(exp_win_q.pop_front()));
                    end
                    en_run = 0;
                end
                if (bus.res_valid) begin
                    if (rep_prev) begin
                        chk("res_step_stable", 64'(bus.res_step), 64'(held_step));
                        chk("res_count_stable", 64'(bus.res_count), 64'(held_cnt));
                    end
                    held_step = bus.res_step;
                    held_cnt  = bus.res_count;
                    if (bus.res_ack) begin
                        $display("result step=%0d count=%0d code=0x%0h", bus.res_step, bus.res_count, bus.dac_code);
                        chk("exp_res_avail", 64'(exp_res_q.size() > 0), 64'd1);
                        if (exp_res_q.size() > 0) begin
                            r = exp_res_q.pop_front();
                            chk("res_step", 64'(bus.res_step), 64'(r.step));
                            chk("res_count", 64'(bus.res_count), 64'(r.count));
                        end
                        rep_prev = 1'b0;
                    end else begin
                        rep_prev = 1'b1;
                    end
                end else begin
                    rep_prev = 1'b0;
                end
            end
        end
    end

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.addr  = a;
        bus.data  = d;
        bus.write = 1'b1;
        @(negedge clk);
        bus.write = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.addr = a;
        #1;
        d = bus.data_out;
    endtask

    task automatic flush();
        exp_code_q.delete();
        exp_gap_q.delete();
        exp_win_q.delete();
        exp_res_q.delete();
    endtask

    // Reference model: the point sequence follows from start/step/npts with clamped arithmetic.
    task automatic start_scan(input logic [11:0] sc, input logic [11:0] st, input logic [7:0] np,
                              input logic [7:0] se, input logic [15:0] win, input int b,
                              output bit sat_o);
        int code, gap, wl;
        res_t r;
        sat_o = 1'b0;
        dac_hold = b;
        wr(BASE + 8'd0, sc[7:0]);
        wr(BASE + 8'd1, {4'b0, sc[11:8]});
        wr(BASE + 8'd2, st[7:0]);
        wr(BASE + 8'd3, {4'b0, st[11:8]});
        wr(BASE + 8'd4, np);
        wr(BASE + 8'd5, se);
        wr(BASE + 8'd6, win[7:0]);
        wr(BASE + 8'd7, win[15:8]);
        wl   = (win == 16'd0) ? 64 : int'(win) * 64;
        gap  = ((b + 1 > 2) ? b + 1 : 2) + int'(se) * 256 + 1;
        code = int'(sc);
        for (int i = 0; i < int'(np); i++) begin
            exp_code_q.push_back(12'(code));
            exp_gap_q.push_back(gap);
            exp_win_q.push_back(wl);
            r.step  = 8'(i);
            r.count = 32'(wl);
            exp_res_q.push_back(r);
            if (i < int'(np) - 1) begin
                code += int'(st);
                if (code > 4095) begin
                    code  = 4095;
                    sat_o = 1'b1;
                end
            end
        end
        wr(BASE + 8'd8, 8'h01);
    endtask

    task automatic finish_scan(input string name, input bit sat_e, input logic [7:0] np);
        int n;
        logic [7:0] d;
        n = 0;
        while (!(bus.done && !bus.busy) && n < 20000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({name, "_completed"}, 64'(n < 20000), 64'd1);
        chk({name, "_pending"}, 64'(exp_code_q.size() + exp_gap_q.size() + exp_win_q.size() + exp_res_q.size()), 64'd0);
        rd(BASE + 8'd9, d);
        chk({name, "_status"}, 64'(d), 64'({4'b0, sat_e, 1'b0, 1'b1, 1'b0}));
        rd(BASE + 8'd10, d);
        chk({name, "_index"}, 64'(d), 64'((np == 8'd0) ? 8'd0 : np - 8'd1));
        $display("scan %s complete", name);
    endtask

    initial begin
        logic [7:0] d;
        bit s, act;
        int n;
        rst = 1'b1;
        bus.addr = '0;
        bus.data = '0;
        bus.write = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_res_valid", 64'(bus.res_valid), 64'd0);
        chk("reset_dac_code", 64'(bus.dac_code), 64'd0);
        for (int o = 0; o <= 10; o++) begin
            rd(BASE + 8'(o), d);
            chk($sformatf("reset_reg%0d", o), 64'(d), 64'd0);
        end

        // Register readback and decode boundaries
        for (int o = 0; o < 8; o++) wr(BASE + 8'(o), 8'hA5 ^ 8'(o));
        for (int o = 0; o < 8; o++) begin
            if (o != 3) begin
                rd(BASE + 8'(o), d);
                chk($sformatf("readback_reg%0d", o), 64'(d), 64'((o == 1) ? ((8'hA5 ^ 8'(o)) & 8'h0F) : (8'hA5 ^ 8'(o))));
            end
        end
        rd(BASE + 8'd8, d);  chk("ctrl_reads_zero", 64'(d), 64'd0);
        rd(BASE - 8'd1, d);  chk("below_range", 64'(d), 64'd0);
        rd(BASE + 8'd11, d); chk("above_range", 64'(d), 64'd0);

        // Basic three-point scan with a redundant start while busy
        start_scan(12'h100, 12'h010, 8'd3, 8'd0, 16'd1, 0, s);
        wr(BASE + 8'd8, 8'h01);
        finish_scan("basic", s, 8'd3);

        // Consumer withholds ack for 100 cycles
        ack_hold = 100;
        start_scan(12'h200, 12'h001, 8'd2, 8'd0, 16'd1, 1, s);
        finish_scan("ack_hold", s, 8'd2);
        ack_hold = -1;

        // Code saturation
        start_scan(12'hFF0, 12'h020, 8'd3, 8'd0, 16'd1, 0, s);
        finish_scan("saturate", s, 8'd3);

        // Long dac_busy followed by a two-block settle
        start_scan(12'h321, 12'h000, 8'd1, 8'd2, 16'd1, 500, s);
        finish_scan("settle", s, 8'd1);

        // Zero points: immediate completion, no DAC or counter activity
        wr(BASE + 8'd4, 8'd0);
        wr(BASE + 8'd8, 8'h01);
        #1;
        chk("npts0_done", 64'(bus.done), 64'd1);
        chk("npts0_busy", 64'(bus.busy), 64'd0);
        finish_scan("npts0", 1'b0, 8'd0);

        // Abort together with start while idle: abort wins, done is left alone
        wr(BASE + 8'd8, 8'h03);
        #1;
        chk("abort_start_busy", 64'(bus.busy), 64'd0);
        rd(BASE + 8'd9, d);
        chk("abort_idle_status", 64'(d), 64'h06);

        // Abort in the middle of a counting window
        start_scan(12'h050, 12'h001, 8'd3, 8'd0, 16'd20, 0, s);
        n = 0;
        while (!bus.cnt_enable && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("abort_reached_count", 64'(n < 3000), 64'd1);
        repeat (10) @(negedge clk);
        ignore_partial = 1'b1;
        wr(BASE + 8'd8, 8'h02);
        #1;
        chk("abort_cnt_enable", 64'(bus.cnt_enable), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_dac_code_held", 64'(bus.dac_code), 64'h050);
        rd(BASE + 8'd9, d);
        chk("abort_status", 64'(d), 64'h04);
        act = 1'b0;
        repeat (50) begin
            @(negedge clk);
            #1;
            if (bus.res_valid || bus.cnt_enable || bus.dac_load || bus.cnt_clear) act = 1'b1;
        end
        chk("abort_quiet", 64'(act), 64'd0);
        flush();
        ignore_partial = 1'b0;

        // Randomized scans with config writes landing mid-scan
        for (int k = 0; k < 4; k++) begin
            logic [11:0] sc, st;
            logic [7:0]  np, se;
            logic [15:0] win;
            int          b;
            sc  = 12'($urandom_range(0, 4095));
            st  = (k % 2 == 0) ? 12'($urandom_range(0, 4095)) : 12'($urandom_range(0, 64));
            np  = 8'($urandom_range(1, 4));
            se  = 8'($urandom_range(0, 1));
            win = 16'($urandom_range(0, 2));
            b   = int'($urandom_range(0, 6));
            start_scan(sc, st, np, se, win, b, s);
            wr(BASE + 8'($urandom_range(0, 7)), 8'($urandom));
            wr(BASE + 8'd8, 8'h01);
            finish_scan($sformatf("random%0d", k), s, np);
        end

        // Reset in the middle of a scan
        start_scan(12'h400, 12'h100, 8'd3, 8'd0, 16'd1, 2, s);
        n = 0;
        while (!bus.res_valid && n < 5000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("reset_reached_report", 64'(n < 5000), 64'd1);
        ignore_partial = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midreset_busy", 64'(bus.busy), 64'd0);
        chk("midreset_res_valid", 64'(bus.res_valid), 64'd0);
        chk("midreset_dac_code", 64'(bus.dac_code), 64'd0);
        rd(BASE + 8'd4, d);
        chk("midreset_npts_reg", 64'(d), 64'd0);
        rd(BASE + 8'd9, d);
        chk("midreset_status", 64'(d), 64'd0);
        flush();
        ignore_partial = 1'b0;

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
